// File: rtl/mem_bus_arbiter.sv
// Two-master memory port arbiter: icache line refills and dcache line/single
// transactions share one beat-level memory interface, granted per transaction.
module mem_bus_arbiter #(
  parameter int BEATS      = 4,
  parameter int BEAT_BYTES = 8,
  localparam int CW        = $clog2(BEATS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [63:0]   i_addr,
  output logic          i_rvalid,
  output logic [63:0]   i_rdata,
  output logic          i_done,
  input  logic          d_req,
  input  logic          d_wen,
  input  logic          d_single,
  input  logic [63:0]   d_addr,
  input  logic [63:0]   d_wdata,
  input  logic [7:0]    d_wmask,
  output logic [CW-1:0] d_beat,
  output logic          d_rvalid,
  output logic [63:0]   d_rdata,
  output logic          d_done,
  output logic          mem_valid,
  output logic          mem_wen,
  output logic [63:0]   mem_addr,
  output logic [63:0]   mem_wdata,
  output logic [7:0]    mem_wmask,
  input  logic          mem_ready,
  input  logic [63:0]   mem_rdata
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

  typedef struct packed {
    logic [63:0]   base;
    logic          wen;
    logic          single;
    logic [CW-1:0] len;     // index of the final beat
  } txn_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          last_d, last_d_nxt;
  txn_t          txn, txn_nxt;
  logic          gnt_d, gnt_i, busy, beat_ack, final_beat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      last_d <= 1'b0;
      txn    <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      last_d <= last_d_nxt;
      txn    <= txn_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    last_d_nxt = last_d;
    txn_nxt    = txn;
    // On a tie the side that did not win last time gets the port.
    gnt_d      = d_req && (!i_req || !last_d);
    gnt_i      = i_req && !gnt_d;
    beat_ack   = (state != IDLE) && mem_ready;
    final_beat = beat_ack && (cnt == txn.len);
    case (state)
      IDLE: begin
        if (gnt_d) begin
          state_nxt      = GNT_D;
          cnt_nxt        = '0;
          txn_nxt.base   = d_addr;
          txn_nxt.wen    = d_wen;
          txn_nxt.single = d_single;
          txn_nxt.len    = d_single ? '0 : CW'(BEATS - 1);
        end else if (gnt_i) begin
          state_nxt      = GNT_I;
          cnt_nxt        = '0;
          txn_nxt.base   = i_addr;
          txn_nxt.wen    = 1'b0;
          txn_nxt.single = 1'b0;
          txn_nxt.len    = CW'(BEATS - 1);
        end
      end
      default: begin
        if (final_beat) begin
          state_nxt  = IDLE;
          cnt_nxt    = '0;
          last_d_nxt = (state == GNT_D);
        end else if (beat_ack) begin
          cnt_nxt = cnt + CW'(1);
        end
      end
    endcase
  end

  assign busy      = (state != IDLE);
  assign mem_valid = busy;
  assign mem_wen   = busy && txn.wen;
  assign mem_addr  = busy ? txn.base + 64'(cnt) * 64'(BEAT_BYTES) : '0;
  assign mem_wdata = mem_wen ? d_wdata : '0;
  assign mem_wmask = mem_wen ? (txn.single ? d_wmask : 8'hFF) : 8'h00;

  assign i_rvalid  = (state == GNT_I) && mem_ready;
  assign i_rdata   = i_rvalid ? mem_rdata : '0;
  assign i_done    = (state == GNT_I) && final_beat;

  assign d_rvalid  = (state == GNT_D) && !txn.wen && mem_ready;
  assign d_rdata   = d_rvalid ? mem_rdata : '0;
  assign d_done    = (state == GNT_D) && final_beat;
  assign d_beat    = (state == GNT_D) ? cnt : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: arbitration vector table, directed corner
// sequences, then random traffic against a transaction-level model.
module tb_mem_bus_arbiter;
  localparam int BEATS = 4;
  localparam int BB    = 8;
  localparam logic [63:0] LMASK = 64'(BEATS * BB - 1);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req, d_req, d_wen, d_single, mem_ready;
  logic [63:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic [7:0]  d_wmask;
  logic        i_rvalid, i_done, d_rvalid, d_done, mem_valid, mem_wen;
  logic [63:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic [7:0]  mem_wmask;
  logic [1:0]  d_beat;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.BEATS(BEATS), .BEAT_BYTES(BB)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_wen(d_wen), .d_single(d_single), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_wmask(d_wmask), .d_beat(d_beat),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_done(d_done),
    .mem_valid(mem_valid), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // One cycle of the arbitration table: inputs and the outputs expected that cycle.
  typedef struct packed {
    logic rst, ir, dr, rdy;
    logic mv, irv, idn, drv, ddn;
    logic [1:0] beat;
  } vec_t;

  function automatic vec_t v(logic r, logic ir, logic dr, logic rdy, logic mv,
                             logic irv, logic idn, logic drv, logic ddn, logic [1:0] b);
    return '{r, ir, dr, rdy, mv, irv, idn, drv, ddn, b};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0; d_wen = 1'b0; d_single = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Random-phase reference model state
  logic        act, side_d, last_d, twen, tsing, i_fin, d_fin;
  int          nb, n_idone, n_ddone;
  logic [63:0] base;
  logic [63:0] q[$];

  initial begin
    vec_t tbl[19];
    logic e_act, e_i, e_d, e_rdy;

    i_req = 0; d_req = 0; d_wen = 0; d_single = 0; mem_ready = 0;
    i_addr = 64'h1000; d_addr = 64'h2000; d_wdata = '0; d_wmask = '0; mem_rdata = '0;

    // Reset with requests and ready active: every output must stay zero.
    i_req = 1; d_req = 1; mem_ready = 1; mem_rdata = '1; d_wdata = '1; d_wmask = '1;
    @(negedge clk); #1;
    chk("rst mem_valid", mem_valid, 0); chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_wen", mem_wen, 0);     chk("rst mem_wdata", mem_wdata, 0);
    chk("rst mem_wmask", mem_wmask, 0); chk("rst i_rvalid", i_rvalid, 0);
    chk("rst i_rdata", i_rdata, 0);     chk("rst d_rvalid", d_rvalid, 0);
    chk("rst d_rdata", d_rdata, 0);     chk("rst i_done", i_done, 0);
    chk("rst d_done", d_done, 0);       chk("rst d_beat", d_beat, 0);
    d_wdata = '0; d_wmask = '0;

    // Tie after reset -> D, then I, then tie again -> D.
    //            rst ir dr rdy  mv irv idn drv ddn beat
    tbl = '{ v(1, 0, 0, 0,   0, 0, 0, 0, 0, 0),
             v(0, 1, 1, 1,   0, 0, 0, 0, 0, 0),
             v(0, 1, 1, 1,   1, 0, 0, 1, 0, 0),
             v(0, 1, 1, 0,   1, 0, 0, 0, 0, 1),
             v(0, 1, 1, 1,   1, 0, 0, 1, 0, 1),
             v(0, 1, 1, 1,   1, 0, 0, 1, 0, 2),
             v(0, 1, 1, 1,   1, 0, 0, 1, 1, 3),
             v(0, 1, 0, 1,   0, 0, 0, 0, 0, 0),
             v(0, 1, 0, 1,   1, 1, 0, 0, 0, 0),
             v(0, 1, 0, 1,   1, 1, 0, 0, 0, 0),
             v(0, 1, 0, 1,   1, 1, 0, 0, 0, 0),
             v(0, 1, 0, 1,   1, 1, 1, 0, 0, 0),
             v(0, 1, 1, 1,   0, 0, 0, 0, 0, 0),
             v(0, 1, 1, 1,   1, 0, 0, 1, 0, 0),
             v(0, 1, 1, 1,   1, 0, 0, 1, 0, 1),
             v(0, 1, 1, 1,   1, 0, 0, 1, 0, 2),
             v(0, 1, 1, 1,   1, 0, 0, 1, 1, 3),
             v(0, 1, 0, 0,   0, 0, 0, 0, 0, 0),
             v(0, 1, 0, 0,   1, 0, 0, 0, 0, 0) };
    for (int r = 0; r < 19; r++) begin
      @(negedge clk);
      rst = tbl[r].rst; i_req = tbl[r].ir; d_req = tbl[r].dr; mem_ready = tbl[r].rdy;
      #1;
      chk($sformatf("tbl[%0d] mem_valid", r), mem_valid, tbl[r].mv);
      chk($sformatf("tbl[%0d] i_rvalid", r), i_rvalid, tbl[r].irv);
      chk($sformatf("tbl[%0d] i_done", r), i_done, tbl[r].idn);
      chk($sformatf("tbl[%0d] d_rvalid", r), d_rvalid, tbl[r].drv);
      chk($sformatf("tbl[%0d] d_done", r), d_done, tbl[r].ddn);
      chk($sformatf("tbl[%0d] d_beat", r), d_beat, tbl[r].beat);
    end

    // icache line refill; address toggled and req dropped mid-transaction.
    do_reset();
    i_req = 1; i_addr = 64'h8000_0040; mem_ready = 1; #1;
    chk("A grant cycle mem_valid", mem_valid, 0);
    for (int k = 0; k < BEATS; k++) begin
      @(negedge clk);
      i_addr = 64'hDEAD_0000 + 64'(k * 64);
      if (k == 1) i_req = 0;
      mem_rdata = 64'hC0DE_0000 + 64'(k);
      #1;
      chk($sformatf("A beat%0d mem_valid", k), mem_valid, 1);
      chk($sformatf("A beat%0d mem_addr", k), mem_addr, 64'h8000_0040 + 64'(k * BB));
      chk($sformatf("A beat%0d i_rvalid", k), i_rvalid, 1);
      chk($sformatf("A beat%0d i_rdata", k), i_rdata, 64'hC0DE_0000 + 64'(k));
      chk($sformatf("A beat%0d i_done", k), i_done, (k == BEATS - 1));
      chk($sformatf("A beat%0d d_rvalid", k), d_rvalid, 0);
      chk($sformatf("A beat%0d mem_wmask", k), mem_wmask, 0);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      chk("A after done mem_valid", mem_valid, 0);
      chk("A after done i_rvalid", i_rvalid, 0);
    end

    // Single-beat uncached write with three wait states.
    @(negedge clk);
    d_req = 1; d_wen = 1; d_single = 1; d_addr = 64'hA000_0004; d_wmask = 8'h0F;
    d_wdata = 64'h1122_3344_5566_7788; mem_ready = 0; #1;
    for (int w = 0; w < 4; w++) begin
      @(negedge clk);
      mem_ready = (w == 3);
      #1;
      chk($sformatf("B w%0d mem_valid", w), mem_valid, 1);
      chk($sformatf("B w%0d mem_wen", w), mem_wen, 1);
      chk($sformatf("B w%0d mem_addr", w), mem_addr, 64'hA000_0004);
      chk($sformatf("B w%0d mem_wmask", w), mem_wmask, 8'h0F);
      chk($sformatf("B w%0d mem_wdata", w), mem_wdata, 64'h1122_3344_5566_7788);
      chk($sformatf("B w%0d d_done", w), d_done, (w == 3));
      chk($sformatf("B w%0d d_rvalid", w), d_rvalid, 0);
    end
    @(negedge clk);
    d_req = 0; mem_ready = 0; #1;
    chk("B single beat only", mem_valid, 0);

    // dcache line write: data keyed by d_beat, full mask regardless of d_wmask.
    @(negedge clk);
    d_req = 1; d_wen = 1; d_single = 0; d_addr = 64'hB000_0000; d_wmask = 8'h01; mem_ready = 1; #1;
    for (int k = 0; k < BEATS; k++) begin
      @(negedge clk);
      d_wdata = 64'hDA7A_0000_0000_0000 | 64'(d_beat);
      #1;
      chk($sformatf("C beat%0d d_beat", k), d_beat, k);
      chk($sformatf("C beat%0d mem_wdata", k), mem_wdata, 64'hDA7A_0000_0000_0000 | 64'(k));
      chk($sformatf("C beat%0d mem_wmask", k), mem_wmask, 8'hFF);
      chk($sformatf("C beat%0d mem_addr", k), mem_addr, 64'hB000_0000 + 64'(k * BB));
      chk($sformatf("C beat%0d d_done", k), d_done, (k == BEATS - 1));
    end
    @(negedge clk);
    d_req = 0; d_wen = 0; #1;
    chk("C idle mem_valid", mem_valid, 0);

    // Reset during beat 2 of a dcache read; pending icache request then served.
    @(negedge clk);
    d_req = 1; d_wen = 0; d_single = 0; d_addr = 64'hC000_0000; mem_ready = 1; #1;
    @(negedge clk);
    i_req = 1; i_addr = 64'h4000_0100; mem_rdata = 64'h5555; #1;
    chk("D beat0 d_rvalid", d_rvalid, 1);
    chk("D beat0 d_rdata", d_rdata, 64'h5555);
    chk("D beat0 i_rvalid", i_rvalid, 0);
    @(negedge clk);
    @(negedge clk); #1;
    chk("D beat2 d_beat", d_beat, 2);
    rst = 1; #1;
    chk("D rst mem_valid", mem_valid, 0);
    chk("D rst d_rvalid", d_rvalid, 0);
    chk("D rst d_done", d_done, 0);
    chk("D rst d_beat", d_beat, 0);
    chk("D rst mem_addr", mem_addr, 0);
    d_req = 0;
    @(negedge clk);
    rst = 0; #1;
    chk("D post-rst idle", mem_valid, 0);
    chk("D post-rst d_done", d_done, 0);
    for (int k = 0; k < BEATS; k++) begin
      @(negedge clk); #1;
      chk($sformatf("D ibeat%0d i_rvalid", k), i_rvalid, 1);
      chk($sformatf("D ibeat%0d mem_addr", k), mem_addr, 64'h4000_0100 + 64'(k * BB));
      chk($sformatf("D ibeat%0d i_done", k), i_done, (k == BEATS - 1));
      chk($sformatf("D ibeat%0d d_done", k), d_done, 0);
    end
    @(negedge clk);
    i_req = 0; #1;
    chk("D final idle", mem_valid, 0);

    // Random traffic; last grant was icache, port is idle.
    act = 0; last_d = 0; side_d = 0; twen = 0; tsing = 0; nb = 0;
    i_fin = 0; d_fin = 0; n_idone = 0; n_ddone = 0; q.delete();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(249) == 0);
      if (i_fin) i_req = 0; else if (!i_req && $urandom_range(3) == 0) i_req = 1;
      if (d_fin) d_req = 0; else if (!d_req && $urandom_range(3) == 0) d_req = 1;
      i_fin = 0; d_fin = 0;
      i_addr    = {$urandom, $urandom} & ~LMASK;
      d_addr    = {$urandom, $urandom};
      d_wen     = $urandom_range(1);
      d_single  = $urandom_range(1);
      d_wmask   = 8'($urandom);
      d_wdata   = {$urandom, $urandom};
      mem_rdata = {$urandom, $urandom};
      mem_ready = ($urandom_range(3) != 0);
      #1;
      e_act = act && !rst;
      e_i   = e_act && !side_d;
      e_d   = e_act && side_d;
      e_rdy = mem_ready;
      chk("R mem_valid", mem_valid, e_act);
      chk("R mem_addr", mem_addr, e_act ? q[0] : 64'h0);
      chk("R mem_wen", mem_wen, e_act && twen);
      chk("R mem_wdata", mem_wdata, (e_act && twen) ? d_wdata : 64'h0);
      chk("R mem_wmask", mem_wmask, (e_act && twen) ? (tsing ? d_wmask : 8'hFF) : 8'h00);
      chk("R i_rvalid", i_rvalid, e_i && e_rdy);
      chk("R i_rdata", i_rdata, (e_i && e_rdy) ? mem_rdata : 64'h0);
      chk("R i_done", i_done, e_i && e_rdy && q.size() == 1);
      chk("R d_rvalid", d_rvalid, e_d && !twen && e_rdy);
      chk("R d_rdata", d_rdata, (e_d && !twen && e_rdy) ? mem_rdata : 64'h0);
      chk("R d_done", d_done, e_d && e_rdy && q.size() == 1);
      chk("R d_beat", d_beat, e_d ? 64'(nb - q.size()) : 64'h0);
      if (rst) begin
        act = 0; last_d = 0; q.delete();
      end else if (act) begin
        if (mem_ready) begin
          void'(q.pop_front());
          if (q.size() == 0) begin
            act = 0; last_d = side_d;
            if (side_d) begin d_fin = 1; n_ddone++; end
            else begin i_fin = 1; n_idone++; end
          end
        end
      end else if (i_req || d_req) begin
        side_d = (i_req && d_req) ? !last_d : d_req;
        act    = 1;
        twen   = side_d && d_wen;
        tsing  = side_d && d_single;
        nb     = tsing ? 1 : BEATS;
        base   = side_d ? d_addr : i_addr;
        for (int k = 0; k < nb; k++) q.push_back(base + 64'(k * BB));
      end
      @(negedge clk);
    end
    chk("R icache completions seen", (n_idone > 0), 1);
    chk("R dcache completions seen", (n_ddone > 0), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
